step_counter: RTL
=================

// Module: step_counter
// PURPOSE
//  Registered N-bit up/down counter built on the ripple incrementor idea, generalised to a
//  programmable step, wrap/saturate mode, parallel load and overflow flagging.
//  Sits in the arithmetic library as the sequential sibling of the incrementor.
//  Used for address generation, event counting and timer prescaling.
// PARAMETERS
//  N    4  counter width in bits, legal range 4..8
//  SW   2  step width in bits; step range 0..2^SW-1, SW < N
//  SAT  0  0 = modulo wrap, 1 = saturate at 0 / 2^N-1
// PORTS
//  clk       in   1   clock; rising edge active
//  rst_n     in   1   asynchronous active-low reset
//  en        in   1   count enable
//  load      in   1   parallel load strobe; has priority over en
//  load_val  in   N   value loaded when load=1
//  up_dn     in   1   1 = count up, 0 = count down
//  step      in   SW  increment/decrement amount applied per enabled cycle
//  count     out  N   registered counter value
//  ovf       out  1   registered one-cycle pulse on wrap or saturation clamp
//  tc        out  1   combinational terminal count: (up_dn & count==top) | (~up_dn & count==0)
// BEHAVIOUR
//  - Reset: rst_n=0 asynchronously forces count=0, ovf=0. Release is synchronous to clk.
//  - Priority each edge: load > en > hold.
//  - load=1: count<=load_val, ovf<=0, en/step ignored.
//  - en=1, load=0: up: sum=count+step computed at N+1 bits; down: diff=count-step at N+1 bits.
//    SAT=0: count<=sum[N-1:0] / diff[N-1:0]; ovf<=1 iff carry/borrow (bit N) set.
//    SAT=1: on carry count<=2^N-1, on borrow count<=0, ovf<=1; otherwise as wrap.
//  - en=0, load=0: count holds, ovf<=0 (ovf is never held over two cycles).
//  - step=0 with en=1: count unchanged, ovf<=0.
//  - Latency: one clk from input to count/ovf; tc follows count and up_dn combinationally.
//  - top = 2^N-1, or mod_max when COUNTER_MODULO_EN is defined.
//  - up_dn may change on any cycle; it takes effect on the same edge as the en it accompanies.
//  - Reset mid-count: state discarded immediately, no pending ovf survives reset.
// CONFIGURATION
//  COUNTER_MODULO_EN defined: extra port mod_max in N (wrap/saturate ceiling, >= 1).
//    up: if count+step > mod_max -> SAT=0: count<=count+step-mod_max-1, ovf=1;
//        SAT=1: count<=mod_max, ovf=1.
//    down: if borrow -> SAT=0: count<=mod_max+1-(step-count), ovf=1; SAT=1: count<=0, ovf=1.
//    load_val > mod_max is loaded as-is; the next enabled up step wraps/saturates per the rule above.
//  Not defined: no mod_max port, ceiling is 2^N-1, pure power-of-two arithmetic.
// TESTING (N=4, SW=2 unless noted)
//  1. rst_n=0 mid-count at count=9 -> count=0, ovf=0 immediately, before the next clk edge.
//  2. SAT=0, load 14, up, step=3, en=1 one cycle -> count=1, ovf=1 for one cycle then 0.
//  3. SAT=1, load 1, down, step=2, en=1 -> count=0, ovf=1; next cycle again -> count=0, ovf=1.
//  4. load=1 & en=1, load_val=5, step=3 -> count=5 (load wins), ovf=0; tc=0.
//  5. count=15, up_dn=1 -> tc=1; flip up_dn=0 -> tc=0 same cycle; en=0 -> count holds 15.
//  6. COUNTER_MODULO_EN, mod_max=9, SAT=0, count=8, up, step=3 -> count=1, ovf=1.

Source files
------------

// File: rtl/step_counter.sv
// -----------------------------------------------------------------------------
// step_counter
//   Registered N-bit up/down counter with a programmable step, wrap or
//   saturate behaviour at the ceiling/floor, parallel load and a one-cycle
//   overflow pulse.
//
//   Optional build macro: COUNTER_MODULO_EN
//     Defined   -> adds input mod_max; the ceiling becomes mod_max instead of
//                  2^N-1, and wrapping is modulo (mod_max+1).
//     Undefined -> ceiling is 2^N-1, plain power-of-two arithmetic.
//
//   Parameters
//     N    counter width (4..8)
//     SW   step width (SW < N)
//     SAT  0 = modulo wrap, 1 = saturate at 0 / ceiling
//
//   Ports
//     clk       in   clock, rising edge
//     rst_n     in   asynchronous active-low reset
//     en        in   count enable
//     load      in   parallel load strobe (priority over en)
//     load_val  in   N-bit value loaded when load=1
//     up_dn     in   1 = count up, 0 = count down
//     step      in   SW-bit increment/decrement per enabled cycle
//     mod_max   in   N-bit ceiling (only with COUNTER_MODULO_EN)
//     count     out  registered counter value
//     ovf       out  registered one-cycle pulse on wrap or clamp
//     tc        out  combinational terminal count
// -----------------------------------------------------------------------------
module step_counter #(
    parameter int N   = 4,
    parameter int SW  = 2,
    parameter int SAT = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          load,
    input  logic [N-1:0]  load_val,
    input  logic          up_dn,
    input  logic [SW-1:0] step,
`ifdef COUNTER_MODULO_EN
    input  logic [N-1:0]  mod_max,
`endif
    output logic [N-1:0]  count,
    output logic          ovf,
    output logic          tc
);

    logic [N-1:0] count_reg;
    logic [N-1:0] count_next;
    logic         ovf_reg;
    logic         ovf_next;

    // Ceiling, widened to N+1 bits so the compare against sum is exact.
    logic [N:0] top_ext;
`ifdef COUNTER_MODULO_EN
    assign top_ext = {1'b0, mod_max};
`else
    assign top_ext = {1'b0, {N{1'b1}}};
`endif

    logic [N:0] step_ext;
    logic [N:0] sum;
    logic [N:0] diff;
    logic       over_up;
    logic       under_dn;
    logic [N:0] wrap_up;
    logic [N:0] wrap_dn;

    assign step_ext = {{(N+1-SW){1'b0}}, step};
    assign sum      = {1'b0, count_reg} + step_ext;
    assign diff     = {1'b0, count_reg} - step_ext;

    // With a power-of-two ceiling these reduce to the carry bit and the low
    // N bits of sum; the same expressions also cover an arbitrary mod_max.
    assign over_up  = (sum > top_ext);
    assign under_dn = diff[N];
    assign wrap_up  = sum - top_ext - {{N{1'b0}}, 1'b1};
    // diff is negative (two's complement) on borrow, so ceiling+1+diff is
    // ceiling+1-(step-count).
    assign wrap_dn  = top_ext + {{N{1'b0}}, 1'b1} + diff;

    always_comb begin
        count_next = count_reg;
        ovf_next   = 1'b0;
        if (load) begin
            count_next = load_val;
        end else if (en && (step != '0)) begin
            if (up_dn) begin
                if (over_up) begin
                    ovf_next   = 1'b1;
                    count_next = (SAT != 0) ? top_ext[N-1:0] : wrap_up[N-1:0];
                end else begin
                    count_next = sum[N-1:0];
                end
            end else begin
                if (under_dn) begin
                    ovf_next   = 1'b1;
                    count_next = (SAT != 0) ? '0 : wrap_dn[N-1:0];
                end else begin
                    count_next = diff[N-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign count = count_reg;
    assign ovf   = ovf_reg;
    assign tc    = ( up_dn && ({1'b0, count_reg} == top_ext)) ||
                   (!up_dn && (count_reg == '0));

endmodule
